// File: rtl/load_store_unit_if.sv
// Request/response channel from the execute stage plus the data-memory bus,
// bundled so the unit and its environment share one set of signal names.
interface load_store_unit_if #(
    parameter int XLEN = 64
);
    // Handshake: a request transfers on a rising clk edge where req_valid and
    // req_ready are both 1; the requester holds all req_* fields stable while
    // req_valid is 1 and req_ready is 0. resp_valid is a single-cycle pulse
    // that is never back-pressured; resp_error and resp_rdata are sampled with it.
    logic            req_valid;
    logic            req_ready;
    logic            req_write;
    logic [1:0]      req_size;
    logic            req_unsigned;
    logic [XLEN-1:0] req_addr;
    logic [XLEN-1:0] req_wdata;
    logic            resp_valid;
    logic            resp_error;
    logic [XLEN-1:0] resp_rdata;
    logic            mem_read;
    logic            mem_write;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic [XLEN-1:0] mem_rdata;

    modport master (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        input  mem_rdata,
        output req_ready, resp_valid, resp_error, resp_rdata,
        output mem_read, mem_write, mem_addr, mem_wdata
    );

    modport slave (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        output mem_rdata,
        input  req_ready, resp_valid, resp_error, resp_rdata,
        input  mem_read, mem_write, mem_addr, mem_wdata
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store sequencer for a big-endian, byte-addressed 64-bit data memory.
// Sub-word stores are read-modify-write; loads are sign- or zero-extended.
module load_store_unit #(
    parameter int MEM_BYTES = 2048,
    parameter int XLEN      = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    load_store_unit_if.master   bus,
    output logic [1:0]          dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RESP = 2'd3
    } state_t;

    localparam logic [XLEN-1:0] MAX_ADDR = XLEN'(MEM_BYTES - 8);

    state_t          state_q, state_d;
    logic            wr_q;
    logic [1:0]      size_q;
    logic            uns_q;
    logic            err_q;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] wdata_q;
    logic [55:0]     merge_q;
    logic [XLEN-1:0] rdata_q;

    logic            misaligned;
    logic            req_err;
    logic            sx;
    logic [XLEN-1:0] load_val;
    logic [XLEN-1:0] merged;

    always_comb begin
        misaligned = 1'b0;
        unique case (bus.req_size)
            2'd0:    misaligned = 1'b0;
            2'd1:    misaligned = bus.req_addr[0];
            2'd2:    misaligned = |bus.req_addr[1:0];
            default: misaligned = |bus.req_addr[2:0];
        endcase
        req_err = misaligned || (bus.req_addr > MAX_ADDR);
    end

    // The operand sits in the most-significant bytes of the memory word.
    always_comb begin
        sx       = ~uns_q & bus.mem_rdata[63];
        load_val = bus.mem_rdata;
        unique case (size_q)
            2'd0:    load_val = {{56{sx}}, bus.mem_rdata[63:56]};
            2'd1:    load_val = {{48{sx}}, bus.mem_rdata[63:48]};
            2'd2:    load_val = {{32{sx}}, bus.mem_rdata[63:32]};
            default: load_val = bus.mem_rdata;
        endcase
    end

    // Bytes past the operand come back from the read phase untouched.
    always_comb begin
        merged = wdata_q;
        unique case (size_q)
            2'd0:    merged = {wdata_q[7:0],  merge_q[55:0]};
            2'd1:    merged = {wdata_q[15:0], merge_q[47:0]};
            2'd2:    merged = {wdata_q[31:0], merge_q[31:0]};
            default: merged = wdata_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    if (req_err)
                        state_d = RESP;
                    else if (!bus.req_write || bus.req_size != 2'd3)
                        state_d = RD;
                    else
                        state_d = WR;
                end
            end
            RD:      state_d = wr_q ? WR : RESP;
            WR:      state_d = RESP;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            wr_q    <= 1'b0;
            size_q  <= 2'd0;
            uns_q   <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            merge_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && bus.req_valid) begin
                wr_q    <= bus.req_write;
                size_q  <= bus.req_size;
                uns_q   <= bus.req_unsigned;
                err_q   <= req_err;
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
            end
            if (state_q == RD) begin
                merge_q <= bus.mem_rdata[55:0];
                if (!wr_q)
                    rdata_q <= load_val;
            end
        end
    end

    // Memory-side outputs depend on state and registers only, so reset
    // removes a pending write strobe without waiting for a clock edge.
    assign bus.req_ready  = (state_q == IDLE);
    assign bus.resp_valid = (state_q == RESP);
    assign bus.resp_error = (state_q == RESP) && err_q;
    assign bus.resp_rdata = rdata_q;
    assign bus.mem_read   = (state_q == RD);
    assign bus.mem_write  = (state_q == WR);
    assign bus.mem_addr   = (state_q == RD || state_q == WR) ? addr_q : '0;
    assign bus.mem_wdata  = (state_q == WR) ? merged : '0;
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a byte-array memory model and a
// queue-based scoreboard checked by an independent monitor.
module tb_load_store_unit;
    localparam int MEM_BYTES = 2048;
    localparam int XLEN      = 64;

    // ---------------- clock / reset ----------------
    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] dbg_state;
    always #5 clk = ~clk;

    load_store_unit_if #(.XLEN(XLEN)) bus ();

    load_store_unit #(.MEM_BYTES(MEM_BYTES), .XLEN(XLEN)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- memory model ----------------
    logic [7:0] mem [0:MEM_BYTES-1];
    logic       init_done = 1'b0;

    always_comb begin
        bus.mem_rdata = '0;
        for (int i = 0; i < 8; i++)
            if (int'(bus.mem_addr[15:0]) + i < MEM_BYTES)
                bus.mem_rdata[63-8*i -: 8] = mem[int'(bus.mem_addr[15:0]) + i];
    end

    always @(posedge clk) begin
        if (!init_done) begin
            for (int i = 0; i < MEM_BYTES; i++) mem[i] <= 8'h00;
            mem[7]  <= 8'h08;
            mem[15] <= 8'h07;
        end else if (bus.mem_write) begin
            for (int i = 0; i < 8; i++)
                if (int'(bus.mem_addr[15:0]) + i < MEM_BYTES)
                    mem[int'(bus.mem_addr[15:0]) + i] <= bus.mem_wdata[63-8*i -: 8];
        end
    end

    // ---------------- scoreboard state ----------------
    logic [64:0] exp_q[$];      // {error, rdata}
    int          exp_cyc_q[$];
    logic [63:0] exp_wr_q[$];
    logic [63:0] exp_wa_q[$];
    int          exp_wc_q[$];
    int          checks = 0;
    int          fails  = 0;
    int          read_cycles = 0;
    logic [63:0] last_rdata = '0;
    string       cur_name = "reset";

    // ---------------- monitor ----------------
    initial begin : monitor
        logic [64:0] e;
        int          ec;
        logic [63:0] ew, ea;
        forever begin
            @(negedge clk);
            if (bus.mem_read) read_cycles++;
            checks++;
            if (bus.mem_read && bus.mem_write) begin
                fails++;
                $display("FAIL strobe_overlap (%s): read=%b write=%b, required not both", cur_name, bus.mem_read, bus.mem_write);
            end
            if (!bus.mem_read && !bus.mem_write) begin
                checks++;
                if (bus.mem_addr !== 64'h0 || bus.mem_wdata !== 64'h0) begin
                    fails++;
                    $display("FAIL idle_bus (%s): addr=%h wdata=%h, required 0/0", cur_name, bus.mem_addr, bus.mem_wdata);
                end
            end
            if (bus.mem_write) begin
                checks++;
                if (exp_wr_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_write (%s): addr=%h wdata=%h", cur_name, bus.mem_addr, bus.mem_wdata);
                end else begin
                    ew = exp_wr_q.pop_front();
                    ea = exp_wa_q.pop_front();
                    ec = exp_wc_q.pop_front();
                    if (bus.mem_wdata !== ew || bus.mem_addr !== ea || cyc != ec) begin
                        fails++;
                        $display("FAIL write (%s): addr=%h wdata=%h cyc=%0d, required addr=%h wdata=%h cyc=%0d",
                                 cur_name, bus.mem_addr, bus.mem_wdata, cyc, ea, ew, ec);
                    end
                end
            end
            checks++;
            if (bus.resp_valid) begin
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_resp (%s): err=%b rdata=%h", cur_name, bus.resp_error, bus.resp_rdata);
                end else begin
                    e  = exp_q.pop_front();
                    ec = exp_cyc_q.pop_front();
                    if (bus.resp_error !== e[64] || bus.resp_rdata !== e[63:0] || cyc != ec) begin
                        fails++;
                        $display("FAIL resp (%s): err=%b rdata=%h cyc=%0d, required err=%b rdata=%h cyc=%0d",
                                 cur_name, bus.resp_error, bus.resp_rdata, cyc, e[64], e[63:0], ec);
                    end
                end
            end else if (bus.resp_error !== 1'b0) begin
                fails++;
                $display("FAIL resp_error_idle (%s): got %b, required 0", cur_name, bus.resp_error);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    task automatic issue(input string name, input logic wr, input logic [1:0] sz, input logic uns,
                         input logic [63:0] addr, input logic [63:0] wdata, input logic err,
                         input logic [63:0] exp_load, input int lat, input logic has_wr,
                         input logic [63:0] exp_wdata, input int wr_lat, input int exp_reads);
        int t, r0, n;
        cur_name = name;
        n = 0;
        @(negedge clk);
        while (!bus.req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({name, ".ready"}, {63'h0, bus.req_ready}, 64'h1);
        t  = cyc;
        r0 = read_cycles;
        bus.req_write    = wr;
        bus.req_size     = sz;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wdata;
        bus.req_valid    = 1'b1;
        if (!err && !wr) last_rdata = exp_load;
        exp_q.push_back({err, last_rdata});
        exp_cyc_q.push_back(t + lat);
        if (has_wr) begin
            exp_wr_q.push_back(exp_wdata);
            exp_wa_q.push_back(addr);
            exp_wc_q.push_back(t + wr_lat);
        end
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_addr  = 64'hFFFF_FFFF_FFFF_FFF0;
        bus.req_wdata = 64'hA5A5_A5A5_A5A5_A5A5;
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL %s.timeout: %0d responses outstanding, required 0", name, exp_q.size());
            exp_q.delete(); exp_cyc_q.delete();
        end
        chk({name, ".reads"}, 64'(read_cycles - r0), 64'(exp_reads));
        exp_wr_q.delete(); exp_wa_q.delete(); exp_wc_q.delete();
    endtask

    task automatic ld(input string name, input logic [1:0] sz, input logic uns,
                      input logic [63:0] addr, input logic [63:0] exp);
        issue(name, 1'b0, sz, uns, addr, 64'h0, 1'b0, exp, 2, 1'b0, 64'h0, 0, 1);
    endtask

    task automatic st(input string name, input logic [1:0] sz, input logic [63:0] addr,
                      input logic [63:0] wdata, input logic [63:0] exp_wdata);
        if (sz == 2'd3)
            issue(name, 1'b1, sz, 1'b0, addr, wdata, 1'b0, 64'h0, 2, 1'b1, exp_wdata, 1, 0);
        else
            issue(name, 1'b1, sz, 1'b0, addr, wdata, 1'b0, 64'h0, 3, 1'b1, exp_wdata, 2, 1);
    endtask

    task automatic er(input string name, input logic wr, input logic [1:0] sz, input logic [63:0] addr);
        issue(name, wr, sz, 1'b0, addr, 64'hDEAD_BEEF_0BAD_F00D, 1'b1, 64'h0, 1, 1'b0, 64'h0, 0, 0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin : driver
        int t;
        bus.req_valid    = 1'b0;
        bus.req_write    = 1'b0;
        bus.req_size     = 2'd0;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = '0;
        bus.req_wdata    = '0;
        repeat (3) @(negedge clk);
        chk("rst.ready",      {63'h0, bus.req_ready}, 64'h1);
        chk("rst.resp_valid", {63'h0, bus.resp_valid}, 64'h0);
        chk("rst.mem_read",   {63'h0, bus.mem_read}, 64'h0);
        chk("rst.mem_write",  {63'h0, bus.mem_write}, 64'h0);
        chk("rst.resp_rdata", bus.resp_rdata, 64'h0);
        chk("rst.state",      {62'h0, dbg_state}, 64'h0);
        init_done = 1'b1;
        rst_n     = 1'b1;

        ld("ld_d_0",     2'd3, 1'b0, 64'd0, 64'h0000_0000_0000_0008);
        st("st_b_7",     2'd0, 64'd7, 64'h0000_0000_0000_0080, 64'h8000_0000_0000_0000);
        ld("ld_b_7_s",   2'd0, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FF80);
        ld("ld_b_7_u",   2'd0, 1'b1, 64'd7, 64'h0000_0000_0000_0080);
        st("st_b_8",     2'd0, 64'd8, 64'h0000_0000_0000_00AB, 64'hAB00_0000_0000_0007);
        ld("ld_d_8",     2'd3, 1'b0, 64'd8, 64'hAB00_0000_0000_0007);
        st("st_d_16",    2'd3, 64'd16, 64'h1122_3344_5566_7788, 64'h1122_3344_5566_7788);
        ld("ld_b_16_u",  2'd0, 1'b1, 64'd16, 64'h0000_0000_0000_0011);
        ld("ld_b_23_u",  2'd0, 1'b1, 64'd23, 64'h0000_0000_0000_0088);
        ld("ld_b_23_s",  2'd0, 1'b0, 64'd23, 64'hFFFF_FFFF_FFFF_FF88);
        ld("ld_h_20_s",  2'd1, 1'b0, 64'd20, 64'h0000_0000_0000_5566);
        ld("ld_w_20_s",  2'd2, 1'b0, 64'd20, 64'h0000_0000_5566_7788);
        ld("ld_h_22_s",  2'd1, 1'b0, 64'd22, 64'h0000_0000_0000_7788);
        st("st_h_18",    2'd1, 64'd18, 64'hFFFF_FFFF_FFFF_BEEF, 64'hBEEF_5566_7788_0000);
        ld("ld_d_16",    2'd3, 1'b0, 64'd16, 64'h1122_BEEF_5566_7788);
        ld("ld_h_18_s",  2'd1, 1'b0, 64'd18, 64'hFFFF_FFFF_FFFF_BEEF);
        st("st_w_24",    2'd2, 64'd24, 64'h1234_5678_CAFE_F00D, 64'hCAFE_F00D_0000_0000);
        ld("ld_w_24_u",  2'd2, 1'b1, 64'd24, 64'h0000_0000_CAFE_F00D);
        ld("ld_w_24_s",  2'd2, 1'b0, 64'd24, 64'hFFFF_FFFF_CAFE_F00D);

        er("err_ld_w_2",    1'b0, 2'd2, 64'd2);
        er("err_ld_d_2044", 1'b0, 2'd3, 64'd2044);
        er("err_ld_w_2044", 1'b0, 2'd2, 64'd2044);
        er("err_ld_h_1",    1'b0, 2'd1, 64'd1);
        er("err_st_d_4",    1'b1, 2'd3, 64'd4);
        er("err_ld_b_2041", 1'b0, 2'd0, 64'd2041);
        er("err_st_b_2047", 1'b1, 2'd0, 64'd2047);

        ld("ld_d_2040",   2'd3, 1'b0, 64'd2040, 64'h0);
        st("st_b_2040",   2'd0, 64'd2040, 64'h0000_0000_0000_005A, 64'h5A00_0000_0000_0000);
        ld("ld_b_2040_u", 2'd0, 1'b1, 64'd2040, 64'h0000_0000_0000_005A);
        ld("ld_d_2040b",  2'd3, 1'b0, 64'd2040, 64'h5A00_0000_0000_0000);

        // Sub-word store interrupted by reset while the write strobe is up.
        cur_name = "rst_mid_wr";
        @(negedge clk);
        chk("rst_mid_wr.ready", {63'h0, bus.req_ready}, 64'h1);
        t = cyc;
        bus.req_write    = 1'b1;
        bus.req_size     = 2'd0;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 64'd24;
        bus.req_wdata    = 64'h55;
        bus.req_valid    = 1'b1;
        exp_wr_q.push_back(64'h55FE_F00D_0000_0000);
        exp_wa_q.push_back(64'd24);
        exp_wc_q.push_back(t + 2);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_mid_wr.write_up", {63'h0, bus.mem_write}, 64'h1);
        chk("rst_mid_wr.state_wr", {62'h0, dbg_state}, 64'h2);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mid_wr.write_drop", {63'h0, bus.mem_write}, 64'h0);
        chk("rst_mid_wr.addr_drop",  bus.mem_addr, 64'h0);
        chk("rst_mid_wr.ready",      {63'h0, bus.req_ready}, 64'h1);
        chk("rst_mid_wr.rdata",      bus.resp_rdata, 64'h0);
        last_rdata = 64'h0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_mid_wr.mem24", {56'h0, mem[24]}, 64'hCA);
        chk("rst_mid_wr.mem25", {56'h0, mem[25]}, 64'hFE);
        chk("rst_mid_wr.wr_left", 64'(exp_wr_q.size()), 64'h0);
        exp_wr_q.delete(); exp_wa_q.delete(); exp_wc_q.delete();

        er("post_rst_err",  1'b0, 2'd1, 64'd3);
        ld("post_rst_ld_b", 2'd0, 1'b1, 64'd24, 64'h0000_0000_0000_00CA);
        st("post_rst_st_b", 2'd0, 64'd24, 64'h0000_0000_0000_0055, 64'h55FE_F00D_0000_0000);
        ld("post_rst_ld_w", 2'd2, 1'b1, 64'd24, 64'h0000_0000_55FE_F00D);

        cur_name = "drain";
        repeat (5) @(negedge clk);
        chk("drain.resp_left", 64'(exp_q.size()), 64'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Initiator side of the data memory interface. Accepts one load or store request at a time from the execute stage and sequences the memory-side read/write strobes. The data memory is byte-addressed, big-endian, with combinational 64-bit reads and clocked 64-bit writes. Sub-word stores are built as read-modify-write, and loads are sign- or zero-extended. Sits between the ALU/execute stage and data_memory.

Parameters:
MEM_BYTES, 2048, size of the data memory in bytes; the highest legal base address is MEM_BYTES-8.
XLEN, 64, data and address width.

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous, active-low reset.
req_valid  input  1  request present.
req_ready  output  1  unit can accept a request.
req_write  input  1  1 = store, 0 = load.
req_size  input  2  0 = byte, 1 = half, 2 = word, 3 = double.
req_unsigned  input  1  1 = zero-extend the load result, 0 = sign-extend it.
req_addr  input  XLEN  byte address.
req_wdata  input  XLEN  store data; the low 8*2^size bits are significant.
resp_valid  output  1  one-cycle completion pulse.
resp_error  output  1  misaligned or out-of-range request; qualified by resp_valid.
resp_rdata  output  XLEN  load result; holds its value until the next load response.
mem_read  output  1  read strobe to the memory.
mem_write  output  1  write strobe to the memory.
mem_addr  output  XLEN  memory address.
mem_wdata  output  XLEN  memory write data.
mem_rdata  input  XLEN  combinational read data from the memory.

Behaviour:
- Memory byte order: mem_rdata[63:56] is the byte at address A, and mem_rdata[7:0] is the byte at A+7. An N-byte operand at A therefore occupies mem_rdata[63:64-8N].
- States: IDLE, RD, WR, RESP. State and all registered outputs reset asynchronously to IDLE/0.
- mem_read, mem_write, mem_addr and mem_wdata are decoded from the current state and registers only. Reset therefore deasserts mem_write immediately.
- IDLE: req_ready=1. On req_valid, latch write, size, unsigned, addr and wdata.
  - Error if addr mod 2^size != 0, or if addr > MEM_BYTES-8. Go to RESP with the error flag set; no memory access is made.
  - Otherwise: a load goes to RD; a store with size=3 goes to WR; any other store goes to RD.
- In every non-IDLE state, req_ready=0 and req_valid is ignored.
- RD: mem_read=1 and mem_addr=latched addr.
  - On the clock edge, capture mem_rdata into the merge register.
  - A load goes to RESP and loads resp_rdata = mem_rdata[63:64-8N], sign- or zero-extended to 64 bits.
  - A store goes to WR.
- WR: mem_write=1 and mem_addr=latched addr. Next state is RESP.
  - For size=3, mem_wdata = wdata.
  - For other sizes, mem_wdata = merge register with bits [63:64-8N] replaced by wdata[8N-1:0]. The bytes at A+N..A+7 are written back unchanged.
- RESP: resp_valid=1 for exactly one cycle. resp_error reflects the latched error flag. Next state is IDLE.
  - resp_rdata updates only on a successful load.
  - resp_error and resp_valid are 0 outside RESP.
- Latency from the accepting cycle T:
  - load: resp_valid at T+2
  - double store: T+2
  - sub-word store: T+3
  - error: T+1
  - Next request is accepted at the earliest in the cycle after RESP.
- mem_read and mem_write are never asserted in the same cycle. mem_addr=0 and mem_wdata=0 when neither strobe is asserted.
- Reset mid-operation: the unit returns to IDLE and drops all strobes and the response without completing the access.
  - If reset asserts during WR before the clock edge, no write occurs.
  - Any latched request is discarded.

Test Plan:
- Memory bytes 0..7 = 00..00,08; load size=3 at addr 0 -> resp_valid at T+2, resp_rdata=0x0000000000000008, resp_error=0.
- Memory byte 7 = 0x80; load byte at addr 7, unsigned=0 -> resp_rdata=0xFFFFFFFFFFFFFF80. Same load with unsigned=1 -> 0x0000000000000080.
- Memory bytes 8..15 = 00..00,07; store byte 0xAB at addr 8 -> RD then WR, mem_wdata=0xAB00000000000007, resp at T+3. A following double load at addr 8 returns 0xAB00000000000007.
- Store size=3 of 0x1122334455667788 at addr 16 -> no mem_read, mem_write at T+1, resp at T+2. Byte load at addr 16 then returns 0x11, and at addr 23 returns 0x88.
- Word load at addr 2 (misaligned) and double load at addr 2044 (out of range) -> resp_error=1 at T+1, with mem_read=mem_write=0 throughout.
- Sub-word store with rst_n pulsed low during WR -> mem_write drops immediately, memory contents are unchanged, req_ready=1 after release, and the next request completes normally.
